// File: rtl/bus1to2.sv
// One-master to two-slave address decoder for the 32-bit valid/ready bus.
// The slave is chosen from a registered decode. Unmapped or timed-out requests complete with an error.
module bus1to2 #(
   parameter logic [31:0] S0_BASE  = 32'h0000_0000,
   parameter logic [31:0] S0_MASK  = 32'hF000_0000,
   parameter logic [31:0] S1_BASE  = 32'h1000_0000,
   parameter logic [31:0] S1_MASK  = 32'hF000_0000,
   parameter int unsigned TIMEOUT  = 256,
   parameter int unsigned CNT_W    = 9,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [31:0] m_addr,
   output logic [31:0] m_rdata,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wstrb,
   output logic        m_err,
   output logic        s0_valid,
   input  logic        s0_ready,
   output logic [31:0] s0_addr,
   input  logic [31:0] s0_rdata,
   output logic [31:0] s0_wdata,
   output logic [3:0]  s0_wstrb,
   output logic        s1_valid,
   input  logic        s1_ready,
   output logic [31:0] s1_addr,
   input  logic [31:0] s1_rdata,
   output logic [31:0] s1_wdata,
   output logic [3:0]  s1_wstrb
);

   typedef enum logic [1:0] {IDLE, SEL0, SEL1, ERR} state_t;

   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             s0_hit;
   logic             s1_hit;
   logic             sel_ready;

   assign s0_hit = ((m_addr & S0_MASK) == S0_BASE);
   assign s1_hit = ((m_addr & S1_MASK) == S1_BASE);

   always_comb begin
      sel_ready = 1'b0;
      case (state)
         SEL0:    sel_ready = s0_ready;
         SEL1:    sel_ready = s1_ready;
         default: sel_ready = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (m_valid) begin
                  if (s0_hit)      state <= SEL0;
                  else if (s1_hit) state <= SEL1;
                  else             state <= ERR;
               end
            end
            SEL0, SEL1: begin
               if (!m_valid || sel_ready)              state <= IDLE;
               else if (TO_EN && (cnt == CNT_LAST))    state <= ERR;
               else if (TO_EN)                         cnt   <= cnt + 1'b1;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      m_ready  = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
      s0_valid = 1'b0;
      s0_addr  = '0;
      s0_wdata = '0;
      s0_wstrb = '0;
      s1_valid = 1'b0;
      s1_addr  = '0;
      s1_wdata = '0;
      s1_wstrb = '0;
      case (state)
         SEL0: begin
            s0_valid = m_valid;
            s0_addr  = m_addr;
            s0_wdata = m_wdata;
            s0_wstrb = m_wstrb;
            m_ready  = s0_ready;
            m_rdata  = s0_rdata;
         end
         SEL1: begin
            s1_valid = m_valid;
            s1_addr  = m_addr;
            s1_wdata = m_wdata;
            s1_wstrb = m_wstrb;
            m_ready  = s1_ready;
            m_rdata  = s1_rdata;
         end
         ERR: begin
            m_ready = 1'b1;
            m_err   = 1'b1;
            m_rdata = ERR_DATA;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus1to2.sv
// Directed bench for bus1to2: main instance with TIMEOUT=4, plus an overlapping-window instance.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_bus1to2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        s0_ready, s1_ready;
   logic [31:0] s0_rdata, s1_rdata;

   logic        m_ready, m_err;
   logic [31:0] m_rdata;
   logic        s0_valid, s1_valid;
   logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
   logic [3:0]  s0_wstrb, s1_wstrb;

   logic        o_m_ready, o_m_err;
   logic [31:0] o_m_rdata;
   logic        o_s0_valid, o_s1_valid;
   logic [31:0] o_s0_addr, o_s1_addr, o_s0_wdata, o_s1_wdata;
   logic [3:0]  o_s0_wstrb, o_s1_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus1to2 #(.TIMEOUT(4), .CNT_W(9)) u_dut (
      .clk(clk), .resetn(resetn),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_err(m_err),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_rdata(s0_rdata),
      .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_rdata(s1_rdata),
      .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb)
   );

   bus1to2 #(.S1_BASE(32'h0000_0000), .S1_MASK(32'hF000_0000), .TIMEOUT(4), .CNT_W(9)) u_ovl (
      .clk(clk), .resetn(resetn),
      .m_valid(m_valid), .m_ready(o_m_ready), .m_addr(m_addr), .m_rdata(o_m_rdata),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_err(o_m_err),
      .s0_valid(o_s0_valid), .s0_ready(s0_ready), .s0_addr(o_s0_addr), .s0_rdata(s0_rdata),
      .s0_wdata(o_s0_wdata), .s0_wstrb(o_s0_wstrb),
      .s1_valid(o_s1_valid), .s1_ready(s1_ready), .s1_addr(o_s1_addr), .s1_rdata(s1_rdata),
      .s1_wdata(o_s1_wdata), .s1_wstrb(o_s1_wstrb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      m_valid  = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      s0_rdata = '0;
      s1_rdata = '0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      m_valid = 1'b1;
      m_addr  = 32'h1000_0000;
      tick();
      tick();
      settle();
      checks++;
      if ({m_ready, m_err, m_rdata, s0_valid, s1_valid, s0_addr, s1_addr, s0_wstrb, s1_wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b err=%b rdata=%h v0=%b v1=%b a0=%h a1=%h expected all zero",
                  m_ready, m_err, m_rdata, s0_valid, s1_valid, s0_addr, s1_addr);
      end
      m_valid = 1'b0;
      resetn  = 1'b1;
      tick();
   endtask

   task automatic test_read_s0();
      int nvalid;
      m_valid = 1'b1;
      m_addr  = 32'h0000_0010;
      m_wstrb = 4'b0000;
      settle();
      checks++;
      if ({s0_valid, m_ready} !== 2'b00) begin
         errors++;
         $display("FAIL rd0_decode_cycle got v0=%b rdy=%b expected 0 0", s0_valid, m_ready);
      end
      nvalid = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 3) begin
            s0_ready = 1'b1;
            s0_rdata = 32'h1234_5678;
         end
         settle();
         if (s0_valid === 1'b1 && s0_addr === 32'h0000_0010) nvalid++;
         checks++;
         if (m_ready !== (i == 3)) begin
            errors++;
            $display("FAIL rd0_ready_cycle%0d got %b expected %b", i, m_ready, (i == 3));
         end
         checks++;
         if ({s1_valid, s1_addr, s1_wdata, s1_wstrb} !== '0) begin
            errors++;
            $display("FAIL rd0_s1_quiet cycle%0d got v1=%b a1=%h", i, s1_valid, s1_addr);
         end
      end
      checks++;
      if ({m_rdata, m_err} !== {32'h1234_5678, 1'b0}) begin
         errors++;
         $display("FAIL rd0_completion got rdata=%h err=%b expected 12345678 0", m_rdata, m_err);
      end
      checks++;
      if (nvalid !== 3) begin
         errors++;
         $display("FAIL rd0_valid_count got %0d expected 3", nvalid);
      end
      tick();
      idle_inputs();
      settle();
      checks++;
      if ({m_ready, s0_valid, m_rdata} !== '0) begin
         errors++;
         $display("FAIL rd0_back_idle got rdy=%b v0=%b rdata=%h expected 0 0 0", m_ready, s0_valid, m_rdata);
      end
   endtask

   task automatic test_write_s1();
      m_valid  = 1'b1;
      m_addr   = 32'h1000_0004;
      m_wdata  = 32'hA5A5_A5A5;
      m_wstrb  = 4'b0011;
      s1_ready = 1'b1;
      settle();
      checks++;
      if (m_ready !== 1'b0) begin
         errors++;
         $display("FAIL wr1_ready_ignored_in_idle got %b expected 0", m_ready);
      end
      tick();
      checks++;
      if ({s1_valid, s1_addr, s1_wdata, s1_wstrb} !== {1'b1, 32'h1000_0004, 32'hA5A5_A5A5, 4'b0011}) begin
         errors++;
         $display("FAIL wr1_forward got v=%b a=%h d=%h s=%b expected 1 10000004 a5a5a5a5 0011",
                  s1_valid, s1_addr, s1_wdata, s1_wstrb);
      end
      checks++;
      if ({m_ready, m_err} !== 2'b10) begin
         errors++;
         $display("FAIL wr1_completion got rdy=%b err=%b expected 1 0", m_ready, m_err);
      end
      checks++;
      if ({s0_valid, s0_addr, s0_wdata, s0_wstrb} !== '0) begin
         errors++;
         $display("FAIL wr1_s0_quiet got v0=%b a0=%h d0=%h", s0_valid, s0_addr, s0_wdata);
      end
      tick();
      idle_inputs();
      settle();
   endtask

   task automatic test_unmapped();
      m_valid = 1'b1;
      m_addr  = 32'h2000_0000;
      m_wdata = 32'h1111_2222;
      m_wstrb = 4'b1111;
      tick();
      checks++;
      if ({m_ready, m_err, m_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL unmapped_err got rdy=%b err=%b rdata=%h expected 1 1 deadbeef", m_ready, m_err, m_rdata);
      end
      checks++;
      if ({s0_valid, s1_valid, s0_wdata, s1_wdata} !== '0) begin
         errors++;
         $display("FAIL unmapped_no_slave got v0=%b v1=%b d0=%h d1=%h", s0_valid, s1_valid, s0_wdata, s1_wdata);
      end
      tick();
      idle_inputs();
      settle();
      checks++;
      if ({m_ready, m_err} !== 2'b00) begin
         errors++;
         $display("FAIL unmapped_single_pulse got rdy=%b err=%b expected 0 0", m_ready, m_err);
      end
   endtask

   task automatic test_timeout();
      int  nvalid;
      int  done_at;
      m_valid = 1'b1;
      m_addr  = 32'h0000_0100;
      nvalid  = 0;
      done_at = -1;
      for (int i = 1; i <= 20 && done_at < 0; i++) begin
         tick();
         if (m_ready === 1'b1) begin
            done_at = i;
            checks++;
            if ({m_err, m_rdata, s0_valid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
               errors++;
               $display("FAIL timeout_err got err=%b rdata=%h v0=%b expected 1 deadbeef 0", m_err, m_rdata, s0_valid);
            end
         end else if (s0_valid === 1'b1) begin
            nvalid++;
         end
      end
      checks++;
      if (done_at !== 5) begin
         errors++;
         $display("FAIL timeout_latency got cycle %0d expected 5", done_at);
      end
      checks++;
      if (nvalid !== 4) begin
         errors++;
         $display("FAIL timeout_valid_count got %0d expected 4", nvalid);
      end
      tick();
      m_valid = 1'b0;
      settle();
      checks++;
      if ({m_ready, s0_valid, m_rdata} !== '0) begin
         errors++;
         $display("FAIL timeout_back_idle got rdy=%b v0=%b rdata=%h", m_ready, s0_valid, m_rdata);
      end
      idle_inputs();
   endtask

   task automatic test_ready_wins();
      m_valid = 1'b1;
      m_addr  = 32'h0000_0200;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) begin
            s0_ready = 1'b1;
            s0_rdata = 32'h0BAD_F00D;
         end
         settle();
      end
      checks++;
      if ({m_ready, m_err, m_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL ready_wins_completion got rdy=%b err=%b rdata=%h expected 1 0 0badf00d", m_ready, m_err, m_rdata);
      end
      tick();
      settle();
      checks++;
      if ({m_ready, m_err} !== 2'b00) begin
         errors++;
         $display("FAIL ready_wins_no_err_after got rdy=%b err=%b expected 0 0", m_ready, m_err);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_abort();
      m_valid = 1'b1;
      m_addr  = 32'h1000_0040;
      tick();
      m_valid = 1'b0;
      settle();
      checks++;
      if ({s1_valid, m_ready} !== 2'b00) begin
         errors++;
         $display("FAIL abort_drop got v1=%b rdy=%b expected 0 0", s1_valid, m_ready);
      end
      tick();
      checks++;
      if ({s1_valid, m_ready, m_err} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle got v1=%b rdy=%b err=%b expected 0 0 0", s1_valid, m_ready, m_err);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr;
      int          pulses;
      addr     = 32'h0000_0300;
      m_valid  = 1'b1;
      m_addr   = addr;
      s0_ready = 1'b1;
      s0_rdata = 32'hCAFE_0001;
      pulses   = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if ({o_m_ready, o_s0_valid, o_s1_valid} !== {(i % 2 == 1), (i % 2 == 1), 1'b0}) begin
            errors++;
            $display("FAIL b2b_cycle%0d got rdy=%b v0=%b v1=%b expected %b %b 0",
                     i, o_m_ready, o_s0_valid, o_s1_valid, (i % 2 == 1), (i % 2 == 1));
         end
         if (i % 2 == 1) begin
            checks++;
            if ({o_s0_addr, o_m_rdata, o_m_err} !== {addr, 32'hCAFE_0001, 1'b0}) begin
               errors++;
               $display("FAIL b2b_data%0d got a=%h rdata=%h err=%b expected %h cafe0001 0",
                        i, o_s0_addr, o_m_rdata, o_m_err, addr);
            end
         end
         if (o_m_ready === 1'b1) begin
            pulses++;
            addr   = addr + 32'd4;
            m_addr = addr;
         end
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL b2b_throughput got %0d completions expected 4", pulses);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      m_valid = 1'b1;
      m_addr  = 32'h1000_0020;
      tick();
      tick();
      checks++;
      if (s1_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_stalled got v1=%b expected 1", s1_valid);
      end
      resetn = 1'b0;
      tick();
      checks++;
      if ({s1_valid, s1_addr, m_ready, m_err, m_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs got v1=%b a1=%h rdy=%b err=%b rdata=%h expected all 0",
                  s1_valid, s1_addr, m_ready, m_err, m_rdata);
      end
      resetn = 1'b1;
      settle();
      checks++;
      if (s1_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_idle got v1=%b expected 0", s1_valid);
      end
      tick();
      s1_ready = 1'b1;
      s1_rdata = 32'h7777_0000;
      settle();
      checks++;
      if ({s1_valid, m_ready, m_err, m_rdata} !== {1'b1, 1'b1, 1'b0, 32'h7777_0000}) begin
         errors++;
         $display("FAIL rst_mid_fresh got v1=%b rdy=%b err=%b rdata=%h expected 1 1 0 77770000",
                  s1_valid, m_ready, m_err, m_rdata);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_read_s0();
      test_write_s1();
      test_unmapped();
      test_timeout();
      test_ready_wins();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
